// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, operand-unit FSM encoding, result-history record.
package mips_pkg;

  localparam logic [5:0] ALUop   = 6'h00;
  localparam logic [5:0] LW      = 6'h23;
  localparam logic [5:0] SW      = 6'h2b;
  localparam logic [5:0] ADD_IMM = 6'h08;
  localparam logic [5:0] Jop     = 6'h02;
  localparam logic [5:0] JALop   = 6'h03;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  // History records are sized for the widest configuration; narrower users zero-pad.
  localparam int HIST_AW_MAX = 8;
  localparam int HIST_DW_MAX = 64;

  typedef struct packed {
    logic                   valid;
    logic                   pending;
    logic [HIST_AW_MAX-1:0] rd;
    logic [HIST_DW_MAX-1:0] data;
  } hist_ent_t;

endpackage

// File: rtl/fwd_src_sel.sv
// Per-source operand mux: immediate, EX result, youngest history hit, else register file.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the selection is captured.
module fwd_src_sel #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int DEPTH  = 3
) (
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   rf_data,
  input  logic                imm_sel,
  input  logic [DATA_W-1:0]   imm,
  input  logic                ex_valid,
  input  logic [AW-1:0]       ex_rd,
  input  logic                ex_is_load,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [DEPTH-1:0]    h_valid,
  input  logic [DEPTH-1:0]    h_pending,
  input  logic [DEPTH*AW-1:0] h_rd,
  input  logic [DEPTH*DATA_W-1:0] h_data,
  output logic [DATA_W-1:0]   sel_data
);

  always_comb begin
    sel_data = rf_data;
    // Walk oldest to youngest so the youngest matching entry wins.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (h_valid[k] && (h_rd[k*AW +: AW] == addr))
        sel_data = h_pending[k] ? mem_rdata : h_data[k*DATA_W +: DATA_W];
    end
    if (ex_valid && !ex_is_load && (ex_rd == addr))
      sel_data = ex_result;
    if (addr == '0)
      sel_data = rf_data;
    if (imm_sel)
      sel_data = imm;
  end

endmodule

// File: rtl/fwd_operand_unit.sv
// Decode-stage operand forwarding with load-use stall and result history.
// Latency: op_valid/op_data one cycle after acceptance; a load-use hazard adds one stall cycle.
// Backpressure: id_ready drops for the single hazard cycle; otherwise accepts whenever id_valid.
module fwd_operand_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NSRC   = 2,
  parameter int DEPTH  = 3,
  parameter int AW     = 5
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [NSRC*AW-1:0]     id_src_addr,
  input  logic [NSRC-1:0]        id_src_use,
  input  logic [NSRC*DATA_W-1:0] id_src_rf,
  input  logic [NSRC-1:0]        id_imm_sel,
  input  logic [DATA_W-1:0]      id_imm,
  input  logic                   ex_valid,
  input  logic [AW-1:0]          ex_rd,
  input  logic                   ex_is_load,
  input  logic [DATA_W-1:0]      ex_result,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   op_valid,
  output logic [NSRC*DATA_W-1:0] op_data,
  output logic [15:0]            stall_cnt
);

  hist_ent_t                 hist [DEPTH];
  logic [0:0]                state;
  logic                      hazard;
  logic [NSRC*DATA_W-1:0]    sel_data;
  logic [DEPTH-1:0]          h_valid;
  logic [DEPTH-1:0]          h_pending;
  logic [DEPTH*AW-1:0]       h_rd;
  logic [DEPTH*DATA_W-1:0]   h_data;
  logic                      unused_hist_hi;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
    end else begin
      hist[0].valid   <= ex_valid && (ex_rd != '0);
      hist[0].pending <= ex_is_load;
      hist[0].rd      <= HIST_AW_MAX'(ex_rd);
      hist[0].data    <= HIST_DW_MAX'(ex_result);
      hist[1] <= hist[0];
      // A load leaving MEM picks up its data here, so older entries are never pending.
      if (hist[0].pending) begin
        hist[1].data    <= HIST_DW_MAX'(mem_rdata);
        hist[1].pending <= 1'b0;
      end
      for (int k = 2; k < DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

  // Record bits above DATA_W/AW only ever hold zero padding.
  always_comb begin
    unused_hist_hi = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      unused_hist_hi = unused_hist_hi ^ (^(hist[k].data >> DATA_W)) ^ (^(hist[k].rd >> AW));
  end

  for (genvar k = 0; k < DEPTH; k++) begin : gen_hist_flat
    assign h_valid[k]                  = hist[k].valid;
    assign h_pending[k]                = hist[k].pending;
    assign h_rd[k*AW +: AW]            = hist[k].rd[AW-1:0];
    assign h_data[k*DATA_W +: DATA_W]  = hist[k].data[DATA_W-1:0];
  end

  for (genvar s = 0; s < NSRC; s++) begin : gen_src
    fwd_src_sel #(.DATA_W(DATA_W), .AW(AW), .DEPTH(DEPTH)) u_sel (
      .addr       (id_src_addr[s*AW +: AW]),
      .rf_data    (id_src_rf[s*DATA_W +: DATA_W]),
      .imm_sel    (id_imm_sel[s]),
      .imm        (id_imm),
      .ex_valid   (ex_valid),
      .ex_rd      (ex_rd),
      .ex_is_load (ex_is_load),
      .ex_result  (ex_result),
      .mem_rdata  (mem_rdata),
      .h_valid    (h_valid),
      .h_pending  (h_pending),
      .h_rd       (h_rd),
      .h_data     (h_data),
      .sel_data   (sel_data[s*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      if (id_src_use[s] && !id_imm_sel[s] && (id_src_addr[s*AW +: AW] != '0) &&
          ex_valid && ex_is_load && (ex_rd == id_src_addr[s*AW +: AW]))
        hazard = 1'b1;
    end
    hazard = hazard && id_valid;
  end

  assign id_ready = resetn && ((state == ST_STALL) || (id_valid && !hazard));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= ST_RUN;
      op_valid  <= 1'b0;
      op_data   <= '0;
      stall_cnt <= '0;
    end else if (state == ST_STALL) begin
      state    <= ST_RUN;
      op_valid <= 1'b1;
      op_data  <= sel_data;
    end else if (hazard) begin
      state    <= ST_STALL;
      op_valid <= 1'b0;
      if (stall_cnt != 16'hffff) stall_cnt <= stall_cnt + 16'd1;
    end else begin
      op_valid <= id_valid;
      if (id_valid) op_data <= sel_data;
    end
  end

endmodule

// File: tb/tb_fwd_operand_unit.sv
// Directed-vector bench for fwd_operand_unit with a queue scoreboard on op_valid/op_data.
module tb_fwd_operand_unit;

  logic        clock;
  logic        resetn;
  logic        id_valid;
  logic        id_ready;
  logic [9:0]  id_src_addr;
  logic [1:0]  id_src_use;
  logic [63:0] id_src_rf;
  logic [1:0]  id_imm_sel;
  logic [31:0] id_imm;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic [31:0] ex_result;
  logic [31:0] mem_rdata;
  logic        op_valid;
  logic [63:0] op_data;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb [$];

  fwd_operand_unit dut (
    .clock       (clock),
    .resetn      (resetn),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_src_addr (id_src_addr),
    .id_src_use  (id_src_use),
    .id_src_rf   (id_src_rf),
    .id_imm_sel  (id_imm_sel),
    .id_imm      (id_imm),
    .ex_valid    (ex_valid),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_result   (ex_result),
    .mem_rdata   (mem_rdata),
    .op_valid    (op_valid),
    .op_data     (op_data),
    .stall_cnt   (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [1:0] use_, input logic [31:0] r0, input logic [31:0] r1);
    id_valid    = v;
    id_src_addr = {a1, a0};
    id_src_use  = use_;
    id_src_rf   = {r1, r0};
    id_imm_sel  = 2'b00;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic ld, input logic [31:0] res);
    ex_valid   = v;
    ex_rd      = rd;
    ex_is_load = ld;
    ex_result  = res;
  endtask

  task automatic step(input string name, input logic exp_rdy);
    @(negedge clock);
    chk(name, {63'd0, id_ready}, {63'd0, exp_rdy});
    @(posedge clock);
    #1;
  endtask

  task automatic flush();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 32'd0, 32'd0);
    set_ex(1'b0, 5'd0, 1'b0, 32'd0);
    mem_rdata = 32'd0;
    for (int i = 0; i < 3; i++) step("idle_rdy", 1'b0);
  endtask

  // Monitor: every cycle op_valid is high consumes one expected entry.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clock);
      if (op_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL op_unexpected: got op_valid=1 data %h expected no output", op_data);
        end else begin
          exp = sb.pop_front();
          chk("op_data", op_data, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn     = 1'b0;
    id_imm     = 32'd0;
    mem_rdata  = 32'd0;
    set_ex(1'b0, 5'd0, 1'b0, 32'd0);
    set_id(1'b1, 5'd3, 5'd3, 2'b11, 32'd1, 32'd2);
    @(posedge clock); #1;
    step("rdy_in_reset", 1'b0);
    step("rdy_in_reset2", 1'b0);
    chk("rst_op_valid", {63'd0, op_valid}, 64'd0);
    chk("rst_op_data", op_data, 64'd0);
    chk("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
    resetn = 1'b1;
    flush();

    // EX forwarding of an ALU result
    set_ex(1'b1, 5'd3, 1'b0, 32'h11);
    set_id(1'b1, 5'd3, 5'd7, 2'b11, 32'hdead, 32'h77);
    sb.push_back({32'h77, 32'h11});
    step("ex_fwd_rdy", 1'b1);
    flush();

    // Load-use stall, then MEM data forwarded from pending H[0]
    set_ex(1'b1, 5'd4, 1'b1, 32'h1234);
    set_id(1'b1, 5'd2, 5'd4, 2'b11, 32'h22, 32'h99);
    step("lu_rdy_low", 1'b0);
    chk("lu_stall_cnt", {48'd0, stall_cnt}, 64'd1);
    chk("lu_op_valid_low", {63'd0, op_valid}, 64'd0);
    set_ex(1'b0, 5'd0, 1'b0, 32'd0);
    mem_rdata = 32'hbeef;
    sb.push_back({32'hbeef, 32'h22});
    step("lu_stall_rdy", 1'b1);
    // Load data captured into H[1] on its way out of MEM
    mem_rdata = 32'd0;
    set_id(1'b1, 5'd4, 5'd0, 2'b01, 32'd0, 32'd0);
    sb.push_back({32'd0, 32'hbeef});
    step("h1_rdy", 1'b1);
    flush();

    // Youngest history entry wins; duplicate sources agree; EX beats history
    set_ex(1'b1, 5'd5, 1'b0, 32'hb);
    step("h_fill1", 1'b0);
    set_ex(1'b1, 5'd5, 1'b0, 32'ha);
    step("h_fill2", 1'b0);
    set_ex(1'b0, 5'd0, 1'b0, 32'd0);
    set_id(1'b1, 5'd5, 5'd5, 2'b11, 32'h55, 32'h55);
    sb.push_back({32'ha, 32'ha});
    step("young_rdy", 1'b1);
    set_ex(1'b1, 5'd5, 1'b0, 32'hc);
    set_id(1'b1, 5'd5, 5'd9, 2'b11, 32'h55, 32'h9);
    sb.push_back({32'h9, 32'hc});
    step("ex_over_h_rdy", 1'b1);
    flush();

    // Register 0 never forwards
    set_ex(1'b1, 5'd0, 1'b0, 32'hff);
    set_id(1'b1, 5'd0, 5'd0, 2'b11, 32'd0, 32'h5);
    sb.push_back({32'h5, 32'd0});
    step("r0_rdy", 1'b1);
    set_ex(1'b0, 5'd0, 1'b0, 32'd0);
    set_id(1'b1, 5'd0, 5'd0, 2'b01, 32'd0, 32'd0);
    sb.push_back({32'd0, 32'd0});
    step("r0_hist_rdy", 1'b1);
    flush();

    // Immediate overrides a pending load; unused source does not stall
    set_ex(1'b1, 5'd7, 1'b1, 32'h700);
    set_id(1'b1, 5'd7, 5'd7, 2'b01, 32'h70, 32'h71);
    id_imm_sel = 2'b01;
    id_imm     = 32'h400;
    sb.push_back({32'h71, 32'h400});
    step("imm_rdy", 1'b1);
    set_ex(1'b0, 5'd0, 1'b0, 32'd0);
    set_id(1'b1, 5'd7, 5'd0, 2'b01, 32'h70, 32'h1);
    mem_rdata = 32'h7777;
    sb.push_back({32'h1, 32'h7777});
    step("pend_rdy", 1'b1);
    flush();

    // Reset in the middle of a stall
    set_ex(1'b1, 5'd6, 1'b1, 32'h600);
    set_id(1'b1, 5'd6, 5'd0, 2'b01, 32'h66, 32'd0);
    step("rst_lu_rdy", 1'b0);
    chk("rst_lu_stall_cnt", {48'd0, stall_cnt}, 64'd2);
    resetn = 1'b0;
    set_ex(1'b0, 5'd0, 1'b0, 32'd0);
    step("rst_stall_rdy", 1'b0);
    resetn = 1'b1;
    chk("rst2_op_valid", {63'd0, op_valid}, 64'd0);
    chk("rst2_stall_cnt", {48'd0, stall_cnt}, 64'd0);
    chk("rst2_op_data", op_data, 64'd0);
    mem_rdata = 32'h6666;
    sb.push_back({32'd0, 32'h66});
    step("post_rst_rdy", 1'b1);
    flush();

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_operand_unit.md
FWD_OPERAND_UNIT -- requirements
Module: fwd_operand_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter NSRC, default 2, number of source operands per instruction.
REQ-003 SHALL have parameter DEPTH, default 3, result-history entries (MEM, WB, post-WB, ...), min 2.
REQ-004 SHALL have parameter AW, default 5, register-address width.
REQ-005 clock  in  1  sole clock; all state changes on rising edge.
REQ-006 resetn  in  1  synchronous, active-low reset.
REQ-007 id_valid  in  1  decode stage holds an instruction.
REQ-008 id_ready  out  1  instruction accepted this cycle.
REQ-009 id_src_addr  in  NSRC*AW  source register numbers.
REQ-010 id_src_use  in  NSRC  source actually read.
REQ-011 id_src_rf  in  NSRC*DATA_W  register-file read data.
REQ-012 id_imm_sel, id_imm  in  NSRC, DATA_W  per-source immediate override (e.g. JAL target, ADD_IMM).
REQ-013 ex_valid, ex_rd, ex_is_load, ex_result  in  1, AW, 1, DATA_W  instruction leaving EX.
REQ-014 mem_rdata  in  DATA_W  load data for the load currently in MEM.
REQ-015 op_valid, op_data  out  1, NSRC*DATA_W  registered operands to ID/EX.
REQ-016 stall_cnt  out  16  saturating count of load-use stall cycles.

Function
REQ-017 SHALL keep history H[0..DEPTH-1] of {valid, rd, data, pending}; H[0] is MEM, higher index older.
REQ-018 Every cycle H[0] SHALL load {ex_valid && ex_rd!=0, ex_rd, ex_result, ex_is_load}.
REQ-019 H[1] SHALL load H[0], with data replaced by mem_rdata and pending cleared when H[0].pending.
REQ-020 H[k], k>=2, SHALL load H[k-1]; oldest entry discarded.
REQ-021 Per source, selection priority: id_imm_sel -> id_imm; else EX match (ex_valid, ex_rd==addr, !ex_is_load) -> ex_result; else youngest H match (pending -> mem_rdata, else data); else id_src_rf.
REQ-022 Address 0 SHALL never match; source 0 always yields id_src_rf.
REQ-023 Load-use hazard: id_valid, any source with use=1, imm_sel=0, addr!=0, ex_valid, ex_is_load, ex_rd==addr.
REQ-024 FSM states RUN, STALL; reset state RUN.
REQ-025 RUN: hazard -> STALL, id_ready=0, op_valid<=0; else id_ready=id_valid, op_valid<=id_valid, op_data<=selected.
REQ-026 STALL: exactly one cycle, id_ready=1, op_valid<=1, operands selected per REQ-021 (load now in H[0] pending -> mem_rdata); next RUN.
REQ-027 id_ready combinational from FSM state and hazard; op_valid/op_data latency 1 cycle.
REQ-028 op_data SHALL hold its value when op_valid<=0.
REQ-029 stall_cnt SHALL increment on each RUN->STALL transition, saturating at 16'hFFFF.
REQ-030 Duplicate sources SHALL resolve independently and identically.

Reset
REQ-031 resetn=0 at an edge: all H valid/pending=0, FSM=RUN, op_valid=0, op_data=0, stall_cnt=0.
REQ-032 While resetn=0, id_ready=0; reset mid-STALL SHALL abandon the stall with no op_valid pulse.

Structure
REQ-033 Opcode constants (ALUop, LW, SW, ADD_IMM, Jop, JALop), FSM state encoding, entry record type SHALL reside in shared package mips_pkg.
REQ-034 Per-source selection SHALL be sub-module fwd_src_sel, instantiated NSRC times via generate.

Verification
REQ-035 ex: ADD rd=3 result 0x11; id src0=3 -> next cycle op_valid=1, op_data[0]=0x11.
REQ-036 ex: LW rd=4; id src1=4 -> id_ready=0 one cycle, op_valid=0, stall_cnt=1; then mem_rdata=0xBEEF -> op_data[1]=0xBEEF.
REQ-037 H[0] rd=5 data 0xA, H[1] rd=5 data 0xB; id src0=5 -> op_data[0]=0xA (youngest wins).
REQ-038 ex rd=0 result 0xFF; id src0=0, id_src_rf=0 -> op_data[0]=0.
REQ-039 LW rd=6 hazard, resetn=0 during STALL -> op_valid=0, history cleared, stall_cnt=0.
REQ-040 id_imm_sel[0]=1, id_imm=0x400, ex LW rd=src0 -> no stall, op_data[0]=0x400.
